// File: rtl/load_store_multiple_sequencer.sv
// Expands lmw/stmw into a stream of lwz/stw micro-ops for the load/store unit.
// Optional macro LSM_FLUSH_EN adds flush_i, which abandons a running sequence.
module load_store_multiple_sequencer #(
  parameter int opcodeWidth      = 6,
  parameter int regWidth         = 5,
  parameter int immWith          = 16,
  parameter int formatIndexRange = 5,
  parameter int addressSize      = 64,
  parameter int D                = 3,
  parameter int LdStUnitCode     = 2,
  parameter int lmwOpcode        = 46,
  parameter int stmwOpcode       = 47,
  parameter int lwzOpcode        = 32,
  parameter int stwOpcode        = 36
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic [1:0]                  functionalUnitCode_i,
  input  logic [opcodeWidth-1:0]      opCode_i,
  input  logic [formatIndexRange-1:0] instructionFormat_i,
  input  logic [63:0]                 operand2_i,
  input  logic [regWidth-1:0]         reg1Address_i,
  input  logic [regWidth-1:0]         reg2Address_i,
  input  logic [immWith-1:0]          imm_i,
  output logic                        busy_o,
  output logic                        rejected_o,
  output logic                        error_o,
  output logic                        uopValid_o,
  input  logic                        uopReady_i,
  output logic [opcodeWidth-1:0]      uopOpCode_o,
  output logic [addressSize-1:0]      uopAddress_o,
  output logic [regWidth-1:0]         uopRegAddress_o,
  output logic                        uopLast_o,
`ifdef LSM_FLUSH_EN
  input  logic                        flush_i,
`endif
  output logic                        done_o
);

  typedef enum logic [0:0] {IDLE, ISSUE} state_t;

  state_t                 state_q;
  logic                   busy_q, rejected_q, error_q, done_q;
  logic                   uop_valid_q, uop_last_q;
  logic [opcodeWidth-1:0] uop_opcode_q;
  logic [addressSize-1:0] uop_addr_q;
  logic [regWidth-1:0]    uop_reg_q;

  logic                   is_lmw_d, is_stmw_d, qualify_d, invalid_d;
  logic                   xfer_d, final_xfer_d, can_accept_d, flush_d;
  logic [addressSize-1:0] ea_d;

  // Handshake: a micro-op moves at an edge where uopValid_o && uopReady_i;
  // the uop outputs only change after such a transfer, so they are stable
  // for as long as uopReady_i stays low.
  always_comb begin
    is_lmw_d     = (opCode_i == opcodeWidth'(lmwOpcode));
    is_stmw_d    = (opCode_i == opcodeWidth'(stmwOpcode));
    qualify_d    = enable_i
                && (functionalUnitCode_i == 2'(LdStUnitCode))
                && (instructionFormat_i == formatIndexRange'(D))
                && (is_lmw_d || is_stmw_d);
    invalid_d    = is_lmw_d && (reg2Address_i >= reg1Address_i);
    ea_d         = ((reg2Address_i == '0) ? '0 : addressSize'(operand2_i))
                 + {{(addressSize-immWith){imm_i[immWith-1]}}, imm_i};
    xfer_d       = uop_valid_q && uopReady_i;
    final_xfer_d = xfer_d && uop_last_q;
    // The final handshake edge frees the sequencer for a new request.
    can_accept_d = (state_q == IDLE) || final_xfer_d;
`ifdef LSM_FLUSH_EN
    flush_d      = flush_i;
`else
    flush_d      = 1'b0;
`endif
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      rejected_q   <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      uop_valid_q  <= 1'b0;
      uop_last_q   <= 1'b0;
      uop_opcode_q <= '0;
      uop_addr_q   <= '0;
      uop_reg_q    <= '0;
    end else begin
      rejected_q <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      if (flush_d) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        uop_valid_q <= 1'b0;
        uop_last_q  <= 1'b0;
      end else begin
        if (state_q == ISSUE && xfer_d) begin
          if (uop_last_q) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            uop_valid_q <= 1'b0;
            uop_last_q  <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            uop_addr_q <= uop_addr_q + addressSize'(4);
            uop_reg_q  <= uop_reg_q + 1'b1;
            uop_last_q <= ((uop_reg_q + 1'b1) == '1);
          end
        end
        if (qualify_d && !can_accept_d) begin
          rejected_q <= 1'b1;
        end
        // Acceptance overrides the completion assignments above.
        if (qualify_d && can_accept_d) begin
          if (invalid_d) begin
            error_q <= 1'b1;
          end else begin
            state_q      <= ISSUE;
            busy_q       <= 1'b1;
            uop_valid_q  <= 1'b1;
            uop_addr_q   <= ea_d;
            uop_reg_q    <= reg1Address_i;
            uop_last_q   <= (reg1Address_i == '1);
            uop_opcode_q <= is_lmw_d ? opcodeWidth'(lwzOpcode)
                                     : opcodeWidth'(stwOpcode);
          end
        end
      end
    end
  end

  assign busy_o          = busy_q;
  assign rejected_o      = rejected_q;
  assign error_o         = error_q;
  assign done_o          = done_q;
  assign uopValid_o      = uop_valid_q;
  assign uopLast_o       = uop_last_q;
  assign uopOpCode_o     = uop_opcode_q;
  assign uopAddress_o    = uop_addr_q;
  assign uopRegAddress_o = uop_reg_q;

endmodule

// File: tb/tb_load_store_multiple_sequencer.sv
// Bench for load_store_multiple_sequencer: request table plus corner sequences,
// with a micro-op scoreboard checked at every handshake.
module tb_load_store_multiple_sequencer;

  logic        clk, reset;
  logic        enable;
  logic [1:0]  fu_code;
  logic [5:0]  op_code;
  logic [4:0]  fmt;
  logic [63:0] operand2;
  logic [4:0]  reg1, reg2;
  logic [15:0] imm;
  logic        busy, rejected, error, uop_valid, uop_ready, uop_last, done, flush;
  logic [5:0]  uop_opcode;
  logic [63:0] uop_addr;
  logic [4:0]  uop_reg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;

  // {opcode, address, register, last}
  logic [75:0] exp_q[$];

  load_store_multiple_sequencer dut (
    .clock_i(clk), .reset_i(reset), .enable_i(enable),
    .functionalUnitCode_i(fu_code), .opCode_i(op_code),
    .instructionFormat_i(fmt), .operand2_i(operand2),
    .reg1Address_i(reg1), .reg2Address_i(reg2), .imm_i(imm),
    .busy_o(busy), .rejected_o(rejected), .error_o(error),
    .uopValid_o(uop_valid), .uopReady_i(uop_ready),
    .uopOpCode_o(uop_opcode), .uopAddress_o(uop_addr),
    .uopRegAddress_o(uop_reg), .uopLast_o(uop_last),
`ifdef LSM_FLUSH_EN
    .flush_i(flush),
`endif
    .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic        stall_q = 1'b0;
  logic [75:0] stall_val;
  always @(negedge clk) begin
    logic [75:0] cur, exp;
    cur = {uop_opcode, uop_addr, uop_reg, uop_last};
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && uop_valid) begin
        checks++;
        if (cur !== stall_val) begin
          errors++;
          $display("FAIL stall_hold act=%h exp=%h", cur, stall_val);
        end
      end
      if (uop_valid && uop_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL uop_unexpected act=%h exp=none", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            errors++;
            $display("FAIL uop act=%h exp=%h", cur, exp);
          end
        end
      end
      stall_q   = uop_valid && !uop_ready;
      stall_val = cur;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] ra,
                           input logic [63:0] raval, input logic [15:0] d);
    op_code = op; reg1 = rt; reg2 = ra; operand2 = raval; imm = d;
    fu_code = 2'd2; fmt = 5'd3; enable = 1'b1;
    cycle();
    enable = 1'b0;
  endtask

  // Push the first n micro-ops of a sequence; last flag follows the full count.
  task automatic push_seq(input logic [5:0] op, input logic [4:0] rt, input logic [63:0] ea,
                          input int n);
    int cnt;
    logic [4:0] r;
    cnt = 32 - int'(rt);
    for (int i = 0; i < cnt && i < n; i++) begin
      r = rt + 5'(i);
      exp_q.push_back({(op == 6'd46) ? 6'd32 : 6'd36, ea + 64'(4 * i), r, (i == cnt - 1)});
    end
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int cyc = 0;
    while (!done && cyc < budget) begin
      uop_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      cyc++;
    end
    check("done_seen", done, 1'b1);
    uop_ready = 1'b1;
    cycle();
    check("done_pulse", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("done_count", done_cnt, exp_done);
    check("queue_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [63:0] raval;
    logic [15:0] imm;
    logic [63:0] exp_ea;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{6'd46, 5'd29, 5'd3,  64'h1000,             16'h0010, 64'h1010,             1'b0};
    vecs[1] = '{6'd47, 5'd31, 5'd0,  64'h5555,             16'hFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{6'd46, 5'd4,  5'd10, 64'h1234,             16'h0000, 64'h0,                1'b1};
    vecs[3] = '{6'd46, 5'd31, 5'd31, 64'h40,               16'h0000, 64'h0,                1'b1};
    vecs[4] = '{6'd47, 5'd0,  5'd0,  64'hDEAD,             16'h0100, 64'h100,              1'b0};
    vecs[5] = '{6'd46, 5'd30, 5'd2,  64'hFFFFFFFFFFFFFFF8, 16'h0008, 64'h0,                1'b0};
    vecs[6] = '{6'd47, 5'd20, 5'd25, 64'h8000,             16'h8000, 64'h0,                1'b0};

    reset = 1'b1; enable = 1'b0; fu_code = '0; op_code = '0; fmt = '0; operand2 = '0;
    reg1 = '0; reg2 = '0; imm = '0; uop_ready = 1'b1; flush = 1'b0;
    repeat (3) cycle();
    check("reset_outputs", {busy, rejected, error, uop_valid, uop_last, done, uop_opcode,
                            uop_reg}, '0);
    check("reset_addr", uop_addr, 64'h0);
    reset = 1'b0;
    cycle();

    for (int k = 0; k < 7; k++) begin
      if (!vecs[k].exp_err) push_seq(vecs[k].op, vecs[k].rt, vecs[k].exp_ea, 32);
      uop_ready = 1'b1;
      drive_req(vecs[k].op, vecs[k].rt, vecs[k].ra, vecs[k].raval, vecs[k].imm);
      check("vec_error", error, vecs[k].exp_err);
      check("vec_busy", busy, !vecs[k].exp_err);
      check("vec_valid", uop_valid, !vecs[k].exp_err);
      if (vecs[k].exp_err) begin
        cycle();
        check("error_pulse", error, 1'b0);
        check("error_no_uop", uop_valid, 1'b0);
      end else begin
        check("vec_first_ea", uop_addr, vecs[k].exp_ea);
        exp_done++;
        wait_done(400, 1'b1);
      end
    end

    // Non-qualifying requests are ignored, even ones that would be invalid lmw forms.
    for (int k = 0; k < 3; k++) begin
      op_code = (k == 2) ? 6'd32 : 6'd46; reg1 = 5'd4; reg2 = 5'd10;
      fu_code = (k == 0) ? 2'd1 : 2'd2; fmt = (k == 1) ? 5'd2 : 5'd3; enable = 1'b1;
      cycle();
      enable = 1'b0;
      check("ignored_quiet", {uop_valid, busy, error, rejected}, 4'b0);
    end

    // Single-uop stmw: busy for exactly one cycle.
    push_seq(6'd47, 5'd31, 64'hFFFFFFFFFFFFFFFC, 32);
    drive_req(6'd47, 5'd31, 5'd0, 64'h0, 16'hFFFC);
    check("single_last", uop_last, 1'b1);
    check("single_busy", busy, 1'b1);
    cycle();
    exp_done++;
    check("single_busy_off", busy, 1'b0);
    check("single_done", done, 1'b1);
    cycle();

    // Stall on the second micro-op for two cycles.
    push_seq(6'd47, 5'd28, 64'h2000, 32);
    drive_req(6'd47, 5'd28, 5'd5, 64'h2000, 16'h0000);
    cycle();
    uop_ready = 1'b0;
    cycle();
    check("stall_addr", uop_addr, 64'h2004);
    cycle();
    check("stall_reg", uop_reg, 5'd29);
    exp_done++;
    wait_done(50, 1'b0);

    // Request during ISSUE is rejected; running sequence continues.
    push_seq(6'd46, 5'd28, 64'h100, 32);
    drive_req(6'd46, 5'd28, 5'd1, 64'h100, 16'h0000);
    drive_req(6'd46, 5'd20, 5'd0, 64'h0, 16'h0000);
    check("rejected", rejected, 1'b1);
    check("reject_addr", uop_addr, 64'h104);
    cycle();
    check("reject_pulse", rejected, 1'b0);
    exp_done++;
    wait_done(50, 1'b0);

    // Request at the final-handshake edge is accepted, not rejected.
    push_seq(6'd47, 5'd31, 64'h8, 32);
    push_seq(6'd47, 5'd30, 64'h40, 32);
    drive_req(6'd47, 5'd31, 5'd0, 64'h0, 16'h0008);
    drive_req(6'd47, 5'd30, 5'd0, 64'h0, 16'h0040);
    check("chain_done", done, 1'b1);
    check("chain_rejected", rejected, 1'b0);
    check("chain_valid", uop_valid, 1'b1);
    check("chain_addr", uop_addr, 64'h40);
    exp_done += 2;
    cycle();
    wait_done(50, 1'b0);

    // Reset after two micro-ops: everything clears, no done.
    push_seq(6'd46, 5'd20, 64'h200, 2);
    drive_req(6'd46, 5'd20, 5'd0, 64'h0, 16'h0200);
    cycle();
    cycle();
    reset = 1'b1; uop_ready = 1'b0;
    cycle();
    check("midreset_outputs", {busy, rejected, error, uop_valid, uop_last, done}, '0);
    check("midreset_addr", uop_addr, 64'h0);
    reset = 1'b0; uop_ready = 1'b1;
    repeat (4) cycle();
    check("midreset_no_done", done_cnt, exp_done);
    check("midreset_queue", exp_q.size(), 0);

`ifdef LSM_FLUSH_EN
    // Flush after the first micro-op: the flushed-edge transfer still counts.
    push_seq(6'd46, 5'd30, 64'h80, 1);
    drive_req(6'd46, 5'd30, 5'd0, 64'h0, 16'h0080);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_valid", uop_valid, 1'b0);
    check("flush_busy", busy, 1'b0);
    repeat (3) cycle();
    check("flush_no_done", done_cnt, exp_done);
    check("flush_queue", exp_q.size(), 0);
    flush = 1'b1;
    drive_req(6'd47, 5'd31, 5'd0, 64'h0, 16'h0000);
    flush = 1'b0;
    check("flush_idle_block", {uop_valid, busy}, 2'b00);
    cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
